// File: rtl/satatx_frame_arbiter.sv
// Whole-frame round-robin arbiter feeding the SATA scrambler/CRC path.
// Truncates over-long FIS frames and latches the scrambler enable per frame.
module satatx_frame_arbiter #(
  parameter int MAX_WORDS    = 2049,
  parameter int LGMAX        = 12,
  parameter bit OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_cfg_scrambler_en,
  output logic        o_scrambler_en,
  input  logic        S0_AXIS_TVALID,
  output logic        S0_AXIS_TREADY,
  input  logic [31:0] S0_AXIS_TDATA,
  input  logic        S0_AXIS_TLAST,
  input  logic        S1_AXIS_TVALID,
  output logic        S1_AXIS_TREADY,
  input  logic [31:0] S1_AXIS_TDATA,
  input  logic        S1_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TID,
  output logic        o_busy,
  output logic        o_overlength
);
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  localparam logic [LGMAX-1:0] LAST_IDX = LGMAX'(MAX_WORDS - 1);

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic [LGMAX-1:0]  count;
  logic              ld, src_valid, src_last, src_ready, accept, at_max, start;
  logic [31:0]       src_data;

  assign ld        = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign src_valid = grant ? S1_AXIS_TVALID : S0_AXIS_TVALID;
  assign src_last  = grant ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
  assign src_data  = grant ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
  assign at_max    = (count == LAST_IDX);
  assign accept    = (state == PASS) && src_valid && ld;
  assign start     = (state == IDLE) && (S0_AXIS_TVALID || S1_AXIS_TVALID);
  assign o_busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    src_ready = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = PASS;
        // Contention goes to whichever source did not win last time
        if (S0_AXIS_TVALID && S1_AXIS_TVALID) grant_nxt = !grant;
        else                                  grant_nxt = S1_AXIS_TVALID;
      end
      PASS: begin
        src_ready = ld;
        if (accept) begin
          if (src_last)    state_nxt = IDLE;
          else if (at_max) state_nxt = DROP;
        end
      end
      DROP: begin
        src_ready = 1'b1;
        if (src_valid && src_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    S0_AXIS_TREADY = src_ready && !grant;
    S1_AXIS_TREADY = src_ready && grant;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state          <= IDLE;
      grant          <= 1'b1;
      count          <= '0;
      o_scrambler_en <= 1'b1;
      o_overlength   <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      o_overlength <= accept && !src_last && at_max;
      if (start) begin
        count          <= '0;
        o_scrambler_en <= i_cfg_scrambler_en;
      end else if (accept) begin
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TID    <= 1'b0;
    end else if (accept) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= src_data;
      M_AXIS_TLAST  <= src_last || at_max;
      M_AXIS_TID    <= grant;
    end else if (ld) begin
      M_AXIS_TVALID <= 1'b0;
      if (OPT_LOWPOWER) begin
        M_AXIS_TDATA <= '0;
        M_AXIS_TLAST <= 1'b0;
      end
    end
  end
endmodule

// File: doc/satatx_frame_arbiter.md
Name: satatx_frame_arbiter

Overview:
- Transmit-side frame scheduler in front of the SATA scrambler.
- Shares a single scrambler/CRC datapath between two FIS sources: source 0 (command/control FIS) and source 1 (data FIS).
- Grants whole frames, round-robin, and never interleaves frames.
- Enforces the maximum FIS length and latches the scrambler enable so it changes only on frame boundaries.

Parameters:
- MAX_WORDS, 2049, maximum dwords per frame (FIS header plus 8 KB payload); must be ≥ 2.
- LGMAX, 12, counter width; 2^LGMAX must exceed MAX_WORDS.
- OPT_LOWPOWER, 1, forces M_AXIS_TDATA/TLAST to zero whenever M_AXIS_TVALID is low.

Ports:
- S_AXI_ACLK  input  1  clock
- S_AXI_ARESETN  input  1  reset, asynchronous, active-low
- i_cfg_scrambler_en  input  1  requested scrambler enable
- o_scrambler_en  output  1  frame-latched scrambler enable, drives scrambler config
- S0_AXIS_TVALID/TREADY/TDATA[31:0]/TLAST  in/out/in/in  1/1/32/1  source 0 stream
- S1_AXIS_TVALID/TREADY/TDATA[31:0]/TLAST  in/out/in/in  1/1/32/1  source 1 stream
- M_AXIS_TVALID/TREADY/TDATA[31:0]/TLAST  out/in/out/out  1/1/32/1  to scrambler
- M_AXIS_TID  output  1  source index of the current output word
- o_busy  output  1  high while a frame is in progress (state != IDLE)
- o_overlength  output  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (asynchronous assert; deassert sampled on clock):
  - state = IDLE, M_AXIS_TVALID = 0, TDATA = 0, TLAST = 0, TID = 0.
  - o_busy = 0, o_overlength = 0, o_scrambler_en = 1, word counter = 0.
  - last-grant = 1, so source 0 wins first.
- Output stage:
  - Single registered stage; load enable ld = !M_AXIS_TVALID || M_AXIS_TREADY.
  - Latency 1 cycle from accepted input to M_AXIS_TVALID.
  - Output holds stable while TVALID && !TREADY.
- States:
  - IDLE: S0/S1_TREADY = 0.
    - If any source is valid, grant it. If both are valid, grant the one ≠ last-grant.
    - On grant: record last-grant = granted source, sample o_scrambler_en <= i_cfg_scrambler_en, clear counter, go to PASS.
    - Grant decision takes one cycle; the first word is accepted no earlier than the next cycle.
  - PASS: granted Sx_TREADY = ld; the other source's TREADY = 0.
    - On each accepted word: counter++, output word copied with TID = granted source.
    - Accepted word with TLAST: M_TLAST = 1, go to IDLE.
    - Accepted word with count == MAX_WORDS-1 and no TLAST: force M_TLAST = 1, pulse o_overlength, go to DROP.
  - DROP: granted Sx_TREADY = 1 (not gated by ld).
    - Words are discarded; no output.
    - On the accepted word with TLAST, go to IDLE.
- A frame accepted with TLAST exactly at word MAX_WORDS is legal and raises no error.
- i_cfg_scrambler_en changes mid-frame are ignored until the next grant.
- Source valid drops mid-frame: grant is held, and no other source is served.
- Reset mid-frame: the partial frame is abandoned. The upstream source is responsible for resending; the arbiter does not resume it.
- AXI stream rules:
  - Sources must hold TDATA/TLAST stable while TVALID && !TREADY.
  - The arbiter guarantees the same on M_AXIS.

Test Plan:
- Single S0 frame of 5 words, M_TREADY = 1: M_AXIS emits 5 words, TID = 0, TLAST on word 5; first output 2 cycles after S0_TVALID rises; o_busy high for the frame.
- S0 and S1 both valid from reset with 3-word frames: order S0, S1, S0, S1; no interleave; TID follows the granted source.
- Backpressure: M_TREADY toggles 1,0,0,1 during a frame of 0x11111111..0x44444444: output data and TLAST stable while stalled; all 4 words appear in order with none lost.
- Overlength: MAX_WORDS = 4, S1 frame of 7 words: 4 words output with TLAST on word 4; o_overlength pulses once; words 5–7 dropped; next grant follows S1's TLAST.
- i_cfg_scrambler_en 1→0 at word 2 of a frame: o_scrambler_en stays 1 until the next frame's grant, then becomes 0.
- Reset asserted mid-frame (asynchronous, between edges): M_AXIS_TVALID drops immediately; after release the arbiter is IDLE and the next grant goes to S0.
